// File: rtl/tms_seq_pkg.sv
// Shared types and widths for the decode-table address sequencer.
// Used by the sequencer top level and its output holding register.
package tms_seq_pkg;

  localparam int TMS_ADDR_W = 8;
  localparam int TMS_WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/tms_out_reg.sv
// Single-entry valid/ready holding register for (addr, word) pairs.
// Supports load, pass-through on accept, hold on stall, and flush.
module tms_out_reg
  import tms_seq_pkg::*;
#(
  parameter int ADDR_W = TMS_ADDR_W,
  parameter int WORD_W = TMS_WORD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              load_vld,
  input  logic              flush,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [WORD_W-1:0] in_word,
  input  logic              out_ready,
  output logic              can_load,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic [WORD_W-1:0] out_word
);

  // A new entry may be written when the slot is empty or being emptied this cycle.
  assign can_load = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_word  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= load_vld;
      out_addr  <= in_addr;
      out_word  <= in_word;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/tms_addr_sequencer.sv
// Walks an inclusive start..end address range over the decode table and
// streams each captured (addr, word) pair downstream via valid/ready.
module tms_addr_sequencer
  import tms_seq_pkg::*;
#(
  parameter int ADDR_W    = TMS_ADDR_W,
  parameter int WORD_W    = TMS_WORD_W,
  parameter int SKIP_ZERO = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] tbl_addr,
  input  logic [WORD_W-1:0] tbl_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [WORD_W-1:0] out_word
);

  seq_state_e        state;
  logic [ADDR_W-1:0] end_q;
  logic              can_load;
  logic              capture;
  logic              last_addr;
  logic              word_vld;

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign capture   = (state == RUN) && can_load && !abort;
  assign last_addr = (tbl_addr == end_q);
  // Zero words still occupy a capture slot but are never presented downstream.
  assign word_vld  = (SKIP_ZERO == 0) || (tbl_word != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tbl_addr <= '0;
      end_q    <= '0;
    end else if (abort) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            tbl_addr <= start_addr;
            end_q    <= end_addr;
            state    <= RUN;
          end
        end
        RUN: begin
          if (capture) begin
            if (last_addr) state <= DRAIN;
            else            tbl_addr <= tbl_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
          end
        end
        DRAIN: begin
          if (can_load) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  tms_out_reg #(
    .ADDR_W(ADDR_W),
    .WORD_W(WORD_W)
  ) u_out_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (capture),
    .load_vld (word_vld),
    .flush    (abort),
    .in_addr  (tbl_addr),
    .in_word  (tbl_word),
    .out_ready(out_ready),
    .can_load (can_load),
    .out_valid(out_valid),
    .out_addr (out_addr),
    .out_word (out_word)
  );

endmodule

// File: tb/tb_tms_addr_sequencer.sv
// Bench for tms_addr_sequencer: two instances (SKIP_ZERO 0 and 1) share stimulus;
// a range/queue model predicts every accepted word and each done pulse.
module tb_tms_addr_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, out_ready;
  logic [7:0]  start_addr, end_addr;
  logic [1:0]  busy, done, out_valid;
  logic [7:0]  tbl_addr [2];
  logic [7:0]  out_addr [2];
  logic [15:0] tbl_word [2];
  logic [15:0] out_word [2];
  logic [255:0] zmask;

  int n_checks = 0;
  int n_pass   = 0;

  // model state per instance
  logic [7:0]  exp_addr [2][256];
  logic [15:0] exp_word [2][256];
  int          exp_cnt  [2] = '{0, 0};
  int          rd_ptr   [2] = '{0, 0};
  bit          walk_active [2];
  bit          hold_pend   [2];
  bit          abort_pend  [2];
  bit          done_next   [2];
  logic [7:0]  h_addr [2];
  logic [15:0] h_word [2];
  logic [7:0]  acc_addr [2][64];
  int          acc_n  [2] = '{0, 0};
  int          done_n [2] = '{0, 0};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    tms_addr_sequencer #(
      .ADDR_W(8),
      .WORD_W(16),
      .SKIP_ZERO(g)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .start_addr(start_addr),
      .end_addr  (end_addr),
      .abort     (abort),
      .busy      (busy[g]),
      .done      (done[g]),
      .tbl_addr  (tbl_addr[g]),
      .tbl_word  (tbl_word[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready),
      .out_addr  (out_addr[g]),
      .out_word  (out_word[g])
    );
    assign tbl_word[g] = zmask[tbl_addr[g]] ? 16'h0000 : {tbl_addr[g] ^ 8'h3C, ~tbl_addr[g]};
  end

  function automatic logic [15:0] tbl_fn(input logic [7:0] a);
    return zmask[a] ? 16'h0000 : {a ^ 8'h3C, ~a};
  endfunction

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Monitor: samples mid-cycle, when inputs for the next edge and outputs of the last edge are stable.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (!rst_n) begin
          walk_active[k] = 0; hold_pend[k] = 0; abort_pend[k] = 0; done_next[k] = 0;
          exp_cnt[k] = 0; rd_ptr[k] = 0;
        end else begin
          if (hold_pend[k])
            chk(out_valid[k] && out_addr[k] == h_addr[k] && out_word[k] == h_word[k],
                "hold_stable", {out_addr[k], out_word[k]}, {h_addr[k], h_word[k]});
          if (abort_pend[k])
            chk(!out_valid[k] && !busy[k] && !done[k], "abort_clear",
                {out_valid[k], busy[k], done[k]}, 0);
          if (k == 0 && done_next[0])
            chk(done[0], "done_latency", done[0], 1);
          done_next[k] = 0;
          if (done[k]) begin
            chk(walk_active[k] && rd_ptr[k] == exp_cnt[k], "done_ok", rd_ptr[k], exp_cnt[k]);
            walk_active[k] = 0;
            done_n[k]++;
          end
          if (out_valid[k] && out_ready) begin
            if (rd_ptr[k] < exp_cnt[k])
              chk(out_addr[k] == exp_addr[k][rd_ptr[k]] && out_word[k] == exp_word[k][rd_ptr[k]],
                  "word", {out_addr[k], out_word[k]},
                  {exp_addr[k][rd_ptr[k]], exp_word[k][rd_ptr[k]]});
            else
              chk(1'b0, "extra_word", out_addr[k], 0);
            if (acc_n[k] < 64) acc_addr[k][acc_n[k]] = out_addr[k];
            acc_n[k]++;
            rd_ptr[k]++;
            if (walk_active[k] && rd_ptr[k] == exp_cnt[k]) done_next[k] = 1;
          end
          hold_pend[k]  = out_valid[k] && !out_ready && !abort;
          h_addr[k]     = out_addr[k];
          h_word[k]     = out_word[k];
          abort_pend[k] = abort;
          if (abort) begin
            walk_active[k] = 0; done_next[k] = 0; exp_cnt[k] = 0; rd_ptr[k] = 0;
          end else if (start && !busy[k]) begin
            logic [7:0] span;
            span = end_addr - start_addr;
            exp_cnt[k] = 0;
            rd_ptr[k]  = 0;
            for (int i = 0; i <= int'(span); i++) begin
              logic [7:0] a;
              a = start_addr + 8'(i);
              if (!(k == 1 && tbl_fn(a) == 16'h0000)) begin
                exp_addr[k][exp_cnt[k]] = a;
                exp_word[k][exp_cnt[k]] = tbl_fn(a);
                exp_cnt[k]++;
              end
            end
            walk_active[k] = 1;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] s, input logic [7:0] e);
    start = 1'b1; start_addr = s; end_addr = e;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input bit rnd);
    int n = 0;
    while (busy != 2'b00 && n < budget) begin
      if (rnd) begin
        out_ready = ($urandom_range(0, 3) != 0);
        abort     = ($urandom_range(0, 99) == 0);
        if (busy == 2'b11 && $urandom_range(0, 9) == 0) begin
          start = 1'b1; start_addr = 8'($urandom); end_addr = 8'($urandom);
        end
      end
      tick();
      start = 1'b0;
      abort = 1'b0;
      n++;
    end
    if (busy != 2'b00) chk(1'b0, "idle_timeout", busy, 0);
  endtask

  task automatic clr_logs();
    acc_n[0] = 0; acc_n[1] = 0;
  endtask

  initial begin
    logic [7:0] e3 [4];
    int d0;
    e3 = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    start_addr = '0; end_addr = '0; zmask = '0;
    #2;
    chk(busy == 2'b00 && done == 2'b00 && out_valid == 2'b00, "reset_ctl", {busy, done, out_valid}, 0);
    chk(tbl_addr[0] == 0 && out_addr[0] == 0 && out_word[0] == 0, "reset_data",
        {tbl_addr[0], out_addr[0], out_word[0]}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // 10..13 at full throughput
    out_ready = 1'b1;
    clr_logs();
    do_start(8'h10, 8'h13);
    chk(busy == 2'b11 && out_valid == 2'b00, "t1_first", {busy, out_valid}, 4'b1100);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk(out_valid[0] && out_addr[0] == 8'h10 + 8'(i) && done == 2'b00, "t1_addr",
          out_addr[0], 8'h10 + 8'(i));
      if (i == 0) chk(out_word[0] == 16'h2CEF, "t1_word", out_word[0], 16'h2CEF);
    end
    tick();
    chk(done == 2'b11 && out_valid == 2'b00, "t1_done", {done, out_valid}, 4'b1100);
    tick();
    chk(done == 2'b00 && busy == 2'b00, "t1_idle", {done, busy}, 0);
    chk(acc_n[0] == 4, "t1_count", acc_n[0], 4);

    // single word FE with consumer stalled
    out_ready = 1'b0;
    do_start(8'hFE, 8'hFE);
    tick();
    chk(out_valid[0] && out_addr[0] == 8'hFE, "t2_first", out_addr[0], 8'hFE);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk(out_valid[0] && out_addr[0] == 8'hFE && done == 2'b00, "t2_hold", {done, out_addr[0]}, 8'hFE);
    end
    out_ready = 1'b1;
    tick();
    chk(done == 2'b11, "t2_done", done, 2'b11);
    tick();
    chk(busy == 2'b00, "t2_idle", busy, 0);

    // wrap FE..01
    clr_logs();
    do_start(8'hFE, 8'h01);
    wait_idle(50, 1'b0);
    chk(acc_n[0] == 4, "t3_count", acc_n[0], 4);
    for (int i = 0; i < 4; i++) chk(acc_addr[0][i] == e3[i], "t3_addr", acc_addr[0][i], e3[i]);

    // zero word skipped only by the SKIP_ZERO instance
    zmask[8'h11] = 1'b1;
    clr_logs();
    do_start(8'h10, 8'h12);
    wait_idle(50, 1'b0);
    chk(acc_n[1] == 2, "t4_count", acc_n[1], 2);
    chk(acc_addr[1][0] == 8'h10 && acc_addr[1][1] == 8'h12, "t4_addrs",
        {acc_addr[1][0], acc_addr[1][1]}, 16'h1012);
    chk(acc_n[0] == 3, "t4_count_noskip", acc_n[0], 3);
    zmask[8'h11] = 1'b0;

    // abort on second RUN cycle
    d0 = done_n[0];
    do_start(8'h30, 8'h3F);
    tick();
    chk(out_valid[0] == 1'b1, "t5_valid", out_valid[0], 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk(busy == 2'b00 && out_valid == 2'b00 && done == 2'b00, "t5_abort", {busy, out_valid, done}, 0);
    repeat (3) tick();
    chk(done_n[0] == d0, "t5_no_done", done_n[0], d0);

    // abort and start together in IDLE
    abort = 1'b1;
    do_start(8'h50, 8'h51);
    abort = 1'b0;
    chk(busy == 2'b00, "t5b_abort_wins", busy, 0);

    // async reset mid-walk, then clean single-word walk
    do_start(8'h20, 8'h40);
    for (int i = 0; i < 3; i++) begin
      out_ready = ($urandom_range(0, 1) != 0);
      tick();
    end
    rst_n = 1'b0;
    #1;
    chk(busy == 2'b00 && out_valid == 2'b00 && done == 2'b00, "t6_reset_ctl", {busy, out_valid, done}, 0);
    chk(tbl_addr[0] == 0 && out_addr[0] == 0 && out_word[0] == 0, "t6_reset_data",
        {tbl_addr[0], out_addr[0], out_word[0]}, 0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    clr_logs();
    d0 = done_n[0];
    do_start(8'h00, 8'h00);
    wait_idle(20, 1'b0);
    chk(acc_n[0] == 1 && acc_addr[0][0] == 8'h00, "t6_single", acc_n[0], 1);
    chk(done_n[0] == d0 + 1, "t6_done", done_n[0], d0 + 1);

    // randomized walks
    for (int w = 0; w < 40; w++) begin
      logic [7:0] s;
      for (int i = 0; i < 256; i++) zmask[i] = ($urandom_range(0, 7) == 0);
      s = 8'($urandom);
      do_start(s, s + 8'($urandom_range(0, 24)));
      wait_idle(800, 1'b1);
      tick();
      chk(walk_active[0] == 0 && walk_active[1] == 0, "walk_closed",
          {walk_active[0], walk_active[1]}, 0);
    end

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
